oka_64bit_seq: RTL and testbench

Iterative 64x64 carry-less (GF(2)[x]) polynomial multiplier. It time-shares a single `OKA_32bit` core across the three overlap-free Karatsuba sub-products: even-even, odd-odd and middle. It then recombines the three results into the 127-bit product. It is the area-reduced alternative to the fully parallel 64-bit multiplier and sits behind a valid/ready stream interface.

---
 rtl/oka_64bit_seq.sv | 139 +++++++++++++
 tb/tb_oka_64bit_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/oka_64bit_seq.sv
// Iterative 64x64 carry-less multiplier: one shared 32-bit overlap-free
// Karatsuba core reused for the even, odd and middle sub-products.
module OKA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [62:0] y
);
  function automatic logic [30:0] clmul16(input logic [15:0] x,
                                          input logic [15:0] z);
    logic [30:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (z[i]) r ^= 31'(x) << i;
    return r;
  endfunction

  logic [15:0] ae, ao, be, bo;
  logic [30:0] pe, po, pm;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ae[i] = a[2*i];
      ao[i] = a[2*i+1];
      be[i] = b[2*i];
      bo[i] = b[2*i+1];
    end
  end

  assign pe = clmul16(ae, be);
  assign po = clmul16(ao, bo);
  assign pm = clmul16(ae ^ ao, be ^ bo);

  always_comb begin
    y = '0;
    for (int i = 0; i < 31; i++) begin
      y[2*i]   ^= pe[i];
      y[2*i+1]  = pm[i] ^ pe[i] ^ po[i];
      y[2*i+2] ^= po[i];
    end
  end
endmodule

module oka_64bit_seq #(
  parameter int N = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MUL_E = 3'd1;
  localparam logic [2:0] MUL_O = 3'd2;
  localparam logic [2:0] MUL_M = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]   state;
  logic [63:0]  a_q, b_q;
  logic [62:0]  pe_q, po_q;
  logic [126:0] y_q, y_nxt;
  logic [31:0]  ae, ao, be, bo;
  logic [31:0]  core_a, core_b;
  logic [62:0]  core_y;
  logic         accept;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      ae[i] = a_q[2*i];
      ao[i] = a_q[2*i+1];
      be[i] = b_q[2*i];
      bo[i] = b_q[2*i+1];
    end
  end

  always_comb begin
    core_a = '0;
    core_b = '0;
    unique case (state)
      MUL_E: begin core_a = ae;      core_b = be;      end
      MUL_O: begin core_a = ao;      core_b = bo;      end
      MUL_M: begin core_a = ae ^ ao; core_b = be ^ bo; end
      default: ;
    endcase
  end

  OKA_32bit u_core (
    .a (core_a),
    .b (core_b),
    .y (core_y)
  );

  // Interleave even/odd halves back; core_y is Pm during MUL_M.
  always_comb begin
    y_nxt = '0;
    for (int i = 0; i < 63; i++) begin
      y_nxt[2*i]   ^= pe_q[i];
      y_nxt[2*i+1]  = core_y[i] ^ pe_q[i] ^ po_q[i];
      y_nxt[2*i+2] ^= po_q[i];
    end
  end

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign y         = y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      pe_q  <= '0;
      po_q  <= '0;
      y_q   <= '0;
    end else begin
      unique case (state)
        MUL_E: begin pe_q <= core_y; state <= MUL_O; end
        MUL_O: begin po_q <= core_y; state <= MUL_M; end
        MUL_M: begin y_q  <= y_nxt;  state <= DONE;  end
        default: begin
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            state <= MUL_E;
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end else if (state != DONE) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_oka_64bit_seq.sv
// Randomized bench for oka_64bit_seq against a shift-and-xor
// carry-less multiply model.
module tb_oka_64bit_seq;
  logic         clk = 0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  a, b;
  logic         out_valid;
  logic         out_ready;
  logic [126:0] y;

  int n_tests = 0;
  int n_fail  = 0;

  oka_64bit_seq #(.N(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [126:0] clmul(input logic [63:0] x,
                                         input logic [63:0] z);
    logic [126:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (z[i]) r ^= 127'(x) << i;
    return r;
  endfunction

  task automatic check(input string tag, input logic [126:0] got,
                       input logic [126:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for acceptance, then time the result.
  task automatic do_op(input string tag, input logic [63:0] x,
                       input logic [63:0] z, input logic [126:0] exp);
    int k;
    int w;
    w = 0;
    a = x;
    b = z;
    in_valid = 1;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_ready"}, 127'(in_ready), 127'(1));
    tick();
    in_valid = 0;
    a = $urandom;
    b = $urandom;
    k = 0;
    while (k < 12) begin
      k++;
      if (out_valid) break;
      tick();
    end
    check({tag, "_lat"}, 127'(k), 127'(4));
    check({tag, "_y"}, y, exp);
  endtask

  logic [126:0] e_all;
  logic [126:0] e_top;
  logic [126:0] hold_y;
  logic [63:0]  qa[$];
  logic [63:0]  qb[$];
  logic [126:0] qexp[$];

  initial begin
    rst = 1;
    in_valid = 1;
    out_ready = 1;
    a = 64'd7;
    b = 64'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ovalid", 127'(out_valid), 127'(0));
      check("rst_y", y, 127'(0));
    end
    rst = 0;
    in_valid = 0;
    check("rst_ready", 127'(in_ready), 127'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_idle", 127'({out_valid, in_ready}), 127'(1));
    end

    do_op("one", 64'd1, 64'd1, 127'd1);
    do_op("two", 64'd2, 64'd2, 127'd4);
    do_op("three", 64'd3, 64'd3, 127'd5);
    e_top = 127'd1 << 126;
    do_op("top", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, e_top);
    do_op("ones_x1", '1, 64'd1, 127'h0_FFFF_FFFF_FFFF_FFFF);
    e_all = '0;
    for (int i = 0; i < 127; i += 2) e_all[i] = 1'b1;
    do_op("ones_sq", '1, '1, e_all);
    for (int i = 0; i < 6; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_op("rand", ra, rb, clmul(ra, rb));
    end

    // Backpressure
    tick();
    out_ready = 0;
    begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_op("bp", ra, rb, clmul(ra, rb));
      hold_y = clmul(ra, rb);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      #1;
      check("bp_ready", 127'(in_ready), 127'(0));
      tick();
      check("bp_ovalid", 127'(out_valid), 127'(1));
      check("bp_y", y, hold_y);
    end
    begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      a = ra;
      b = rb;
      in_valid = 1;
      out_ready = 1;
      #1;
      check("bp_rel_ready", 127'(in_ready), 127'(1));
      tick();
      in_valid = 0;
      check("bp_rel_ovalid", 127'(out_valid), 127'(0));
      tick(); tick(); tick();
      check("bp_rel_ovalid4", 127'(out_valid), 127'(1));
      check("bp_rel_y", y, clmul(ra, rb));
      tick();
    end

    // Back-to-back stream
    for (int i = 0; i < 100; i++) begin
      qa.push_back({$urandom, $urandom});
      qb.push_back({$urandom, $urandom});
      qexp.push_back(clmul(qa[i], qb[i]));
    end
    begin
      int idx, got, cyc, last;
      logic acc;
      idx = 0; got = 0; cyc = 0; last = -1;
      a = qa[0];
      b = qb[0];
      in_valid = 1;
      out_ready = 1;
      while (got < 100 && cyc < 1000) begin
        acc = in_ready && in_valid;
        tick();
        cyc++;
        if (acc) begin
          idx++;
          if (idx < 100) begin
            a = qa[idx];
            b = qb[idx];
          end else begin
            in_valid = 0;
          end
        end
        if (out_valid) begin
          check("b2b_y", y, qexp[got]);
          if (last >= 0) check("b2b_gap", 127'(cyc - last), 127'(4));
          last = cyc;
          got++;
        end
      end
      check("b2b_count", 127'(got), 127'(100));
    end

    // Reset mid-operation
    tick();
    a = 64'hDEAD_BEEF_1234_5678;
    b = 64'h0F0F_F0F0_AAAA_5555;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_ovalid", 127'(out_valid), 127'(0));
    check("mid_rst_ready", 127'(in_ready), 127'(1));
    check("mid_rst_y", y, 127'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_rst_discard", 127'(out_valid), 127'(0));
    end
    do_op("after_rst", 64'd3, 64'd5, 127'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
